siso_shift_sequencer: RTL and testbench
=======================================

# siso_shift_sequencer

Controller for the team's parameterized serial-in/serial-out shift register. It accepts a parallel word over a valid/ready handshake and serializes it MSB-first or LSB-first at a programmable bit rate. On the same shift strobes it captures the serial input into a receive word, then presents that word on a second valid/ready handshake. It sits between word-oriented logic and a serial link, and drives the enable/direction strobes for any companion shift stage.

## Interface
- `WIDTH`, default 8: word and shift length in bits; must be ≥ 2.
- `BIT_CYCLES`, default 1: clock cycles per serial bit; must be ≥ 1.

- `clk`  in  1  single clock; all logic is on its rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `tx_data`  in  WIDTH  word to serialize.
- `tx_dir`  in  1  0 = shift left (MSB out first); 1 = shift right (LSB out first).
- `tx_valid`  in  1  tx_data/tx_dir are valid.
- `tx_ready`  out  1  sequencer can accept a word.
- `sdi`  in  1  serial input, sampled on strobe edges.
- `sdo`  out  1  serial output.
- `shift_en`  out  1  one-cycle bit strobe.
- `shift_dir`  out  1  latched direction of the current transfer.
- `busy`  out  1  transfer in progress or result pending.
- `rx_data`  out  WIDTH  captured word.
- `rx_valid`  out  1  rx_data is valid.
- `rx_ready`  in  1  consumer accepts rx_data.

## Operation
- The FSM has three states:
  - IDLE: `tx_ready` = 1. When `tx_valid` && `tx_ready`, load the shift register with `tx_data`, latch `tx_dir`, clear `bit_cnt` and `div_cnt`, and go to SHIFT.
  - SHIFT: `div_cnt` counts 0..BIT_CYCLES-1 and wraps.
    - When `div_cnt` == BIT_CYCLES-1, `shift_en` = 1 for that cycle.
    - On that edge the register shifts: dir 0 → {sr[WIDTH-2:0], sdi}; dir 1 → {sdi, sr[WIDTH-1:1]}. `bit_cnt` increments.
    - The strobe with `bit_cnt` == WIDTH-1 also loads `rx_data` with the shifted value, sets `rx_valid`, and moves the FSM to DONE.
  - DONE: hold `rx_valid` and `rx_data` stable until `rx_ready`. On `rx_valid` && `rx_ready`, clear `rx_valid` and go to IDLE.
- `sdo` is sr[WIDTH-1] when dir = 0 and sr[0] when dir = 1, valid throughout SHIFT. `sdo` is 0 in IDLE and DONE.
- `busy` = (state != IDLE). `tx_ready` = (state == IDLE). `tx_valid` is ignored outside IDLE.
- With `sdo` looped back to `sdi`, `rx_data` equals `tx_data` for either direction (full rotation).
- A word is accepted no sooner than the cycle after `rx_ready` releases DONE; there is no overlap between transfers.
- `bit_cnt` is $clog2(WIDTH) bits wide. `div_cnt` is max(1,$clog2(BIT_CYCLES)) bits wide. No counter wraps past its terminal value.
- Reset mid-transfer or in DONE aborts: no `rx_valid` is issued and the pending word is discarded.

## Timing
- Values after a reset edge:
  - state IDLE; `tx_ready` 1; `busy` 0; `shift_en` 0; `sdo` 0; `shift_dir` 0.
  - `rx_valid` 0; `rx_data` 0; shift register 0.
- Call the accept edge E0; SHIFT cycles are numbered 1, 2, … after E0.
  - Strobes occur in cycles B, 2B, …, WIDTH·B, where B = BIT_CYCLES.
  - `rx_valid` is high from cycle WIDTH·B+1.
  - With B = 1, `shift_en` is high for WIDTH consecutive cycles.
- Each `sdo` bit is stable for B cycles and changes only on the edge after a strobe.
- `rx_data` is registered and changes only on the final-strobe edge.
- Back-to-back throughput is one word per WIDTH·B+2 cycles when `rx_ready` is tied high.

## Structure
- Package `siso_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, DONE; 2 bits);
  - `DIR_LEFT` = 0 and `DIR_RIGHT` = 1 constants.
- Sub-module `siso_bit_timer` (param BIT_CYCLES; inputs clk, rstn, run; output strobe) owns `div_cnt`. The top level owns the FSM, shift register, `bit_cnt` and rx capture.

## Test plan
- Loopback, WIDTH=8, B=1, dir 0, tx 0x1E:
  - `sdo` reads 0,0,0,1,1,1,1,0 on the strobe cycles;
  - `shift_en` is high for 8 cycles;
  - `rx_valid` rises in cycle 9 with `rx_data` 0x1E.
- Loopback, dir 1, tx 0x1E:
  - `sdo` reads 0,1,1,1,1,0,0,0;
  - `rx_data` is 0x1E and `shift_dir` is 1 during the transfer.
- `sdi` tied 1, dir 0, tx 0x00, B=3:
  - strobes in cycles 3, 6, …, 24;
  - `rx_valid` in cycle 25 with `rx_data` 0xFF.
- `rx_ready` held low 5 cycles in DONE while `tx_valid` is high with 0x55:
  - `rx_valid`/`rx_data` stay stable; `tx_ready` 0; 0x55 is not accepted;
  - after `rx_ready` pulses, 0x55 is accepted the next cycle.
- `rstn` low on the 4th strobe of 0xA5:
  - next edge shows all reset values and no `rx_valid`;
  - a subsequent 0x3C loopback completes correctly.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared types and constants for the serial-in/serial-out shift sequencer.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/siso_bit_timer.sv
// Bit-rate divider: run is high in the cycle before every SHIFT cycle, and
// strobe is registered so that it is high in the cycle where div_cnt == BIT_CYCLES-1.
module siso_bit_timer #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    output logic strobe
);

    localparam int unsigned DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [DW-1:0] LAST = DW'(BIT_CYCLES - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic          active;

    // First SHIFT cycle after an accept always starts the count at zero
    always_comb begin
        div_nxt = '0;
        if (active) begin
            div_nxt = (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_cnt <= '0;
            strobe  <= 1'b0;
            active  <= 1'b0;
        end else if (run) begin
            div_cnt <= div_nxt;
            strobe  <= (div_nxt == LAST);
            active  <= 1'b1;
        end else begin
            div_cnt <= '0;
            strobe  <= 1'b0;
            active  <= 1'b0;
        end
    end

endmodule

// File: rtl/siso_shift_sequencer.sv
// Word-to-serial sequencer: serializes tx words MSB- or LSB-first at a
// programmable bit rate while capturing sdi into an rx word on the same strobes.
module siso_shift_sequencer
    import siso_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_dir,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             sdi,
    output logic             sdo,
    output logic             shift_en,
    output logic             shift_dir,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic [CW-1:0]    bit_cnt;
    logic             strobe;
    logic             last_strobe;
    logic             run;
    logic             sdo_next;

    // Shift toward the output end, sdi entering at the far end
    always_comb begin
        sr_shifted = (shift_dir == DIR_RIGHT) ? {sdi, sr[WIDTH-1:1]}
                                              : {sr[WIDTH-2:0], sdi};
        sdo_next   = (shift_dir == DIR_RIGHT) ? sr_shifted[0] : sr_shifted[WIDTH-1];
    end

    assign last_strobe = (state == SHIFT) && strobe && (bit_cnt == LAST_BIT);
    // High whenever the following cycle will be a SHIFT cycle
    assign run         = ((state == IDLE) && tx_valid) ||
                         ((state == SHIFT) && !last_strobe);
    assign shift_en    = strobe;

    siso_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .rstn   (rstn),
        .run    (run),
        .strobe (strobe)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            sr        <= '0;
            shift_dir <= DIR_LEFT;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            sdo       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        sr        <= tx_data;
                        shift_dir <= tx_dir;
                        bit_cnt   <= '0;
                        sdo       <= (tx_dir == DIR_RIGHT) ? tx_data[0] : tx_data[WIDTH-1];
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (strobe) begin
                        sr <= sr_shifted;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= sr_shifted;
                            rx_valid <= 1'b1;
                            sdo      <= 1'b0;
                            state    <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                            sdo     <= sdo_next;
                        end
                    end
                end
                DONE: begin
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_shift_sequencer.sv
// Bench for siso_shift_sequencer: two instances (BIT_CYCLES 1 and 3) checked
// against a per-bit model of the serial stream and the captured word.
module tb_siso_shift_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sel;
    logic       loop;
    logic       sdi_drv;
    logic [7:0] tx_data;
    logic       tx_dir;
    logic       tx_valid;
    logic       rx_ready;

    logic       tx_ready1, sdo1, shift_en1, shift_dir1, busy1, rx_valid1;
    logic [7:0] rx_data1;
    logic       tx_ready3, sdo3, shift_en3, shift_dir3, busy3, rx_valid3;
    logic [7:0] rx_data3;

    logic       tx_ready, sdo, shift_en, shift_dir, busy, rx_valid, sdi;
    logic [7:0] rx_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign tx_ready  = sel ? tx_ready3  : tx_ready1;
    assign sdo       = sel ? sdo3       : sdo1;
    assign shift_en  = sel ? shift_en3  : shift_en1;
    assign shift_dir = sel ? shift_dir3 : shift_dir1;
    assign busy      = sel ? busy3      : busy1;
    assign rx_valid  = sel ? rx_valid3  : rx_valid1;
    assign rx_data   = sel ? rx_data3   : rx_data1;
    assign sdi       = loop ? sdo : sdi_drv;

    siso_shift_sequencer #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_dir(tx_dir),
        .tx_valid(tx_valid && !sel), .tx_ready(tx_ready1), .sdi(sdi), .sdo(sdo1),
        .shift_en(shift_en1), .shift_dir(shift_dir1), .busy(busy1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready)
    );

    siso_shift_sequencer #(.WIDTH(8), .BIT_CYCLES(3)) dut3 (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_dir(tx_dir),
        .tx_valid(tx_valid && sel), .tx_ready(tx_ready3), .sdi(sdi), .sdo(sdo3),
        .shift_en(shift_en3), .shift_dir(shift_dir3), .busy(busy3),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer from IDLE to the first DONE cycle; mode 0 loopback, 1 random sdi, 2 sdi=1
    task automatic xfer(input logic [7:0] data, input logic dir, input int mode);
        int         b;
        int         k;
        logic       ebit;
        logic       s;
        logic [7:0] exp_rx;
        b      = sel ? 3 : 1;
        k      = 0;
        exp_rx = 8'h00;
        loop   = (mode == 0);
        chk("tx_ready_idle", 32'(tx_ready), 32'd1);
        tx_data  = data;
        tx_dir   = dir;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_dir   = 1'($urandom);
        for (int c = 1; c <= 8 * b; c++) begin
            k    = (c - 1) / b;
            ebit = dir ? data[k] : data[7 - k];
            chk("shift_en", 32'(shift_en), ((c % b) == 0) ? 32'd1 : 32'd0);
            chk("sdo", 32'(sdo), 32'(ebit));
            chk("shift_dir", 32'(shift_dir), 32'(dir));
            chk("busy_shift", 32'(busy), 32'd1);
            chk("rx_valid_shift", 32'(rx_valid), 32'd0);
            if (mode == 1) sdi_drv = 1'($urandom);
            else           sdi_drv = 1'b1;
            s = (mode == 0) ? ebit : sdi_drv;
            if ((c % b) == 0) begin
                if (dir) exp_rx[k]     = s;
                else     exp_rx[7 - k] = s;
            end
            @(negedge clk);
        end
        chk("rx_valid_done", 32'(rx_valid), 32'd1);
        chk("rx_data", 32'(rx_data), 32'(exp_rx));
        chk("tx_ready_done", 32'(tx_ready), 32'd0);
        chk("shift_en_done", 32'(shift_en), 32'd0);
        chk("sdo_done", 32'(sdo), 32'd0);
    endtask

    task automatic release_rx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_valid_cleared", 32'(rx_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("tx_ready_back", 32'(tx_ready), 32'd1);
    endtask

    task automatic chk_reset_values();
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_shift_en", 32'(shift_en), 32'd0);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_shift_dir", 32'(shift_dir), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; sel = 1'b0; loop = 1'b0; sdi_drv = 1'b0;
        tx_data = 8'h00; tx_dir = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_values();
        sel = 1'b1;
        chk_reset_values();
        sel = 1'b0;
        rstn = 1'b1;
        @(negedge clk);

        xfer(8'h1E, 1'b0, 0); release_rx();
        xfer(8'h1E, 1'b1, 0); release_rx();

        sel = 1'b1;
        xfer(8'h00, 1'b0, 2); release_rx();
        for (int i = 0; i < 3; i++) begin
            xfer(8'($urandom), 1'($urandom), 1); release_rx();
        end

        sel = 1'b0;
        for (int i = 0; i < 20; i++) begin
            xfer(8'($urandom), 1'($urandom), int'($urandom_range(0, 1))); release_rx();
        end

        // DONE holds while a new word waits; it is taken right after release
        xfer(8'hC3, 1'b0, 0);
        tx_data  = 8'h55;
        tx_dir   = 1'b1;
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rx_valid", 32'(rx_valid), 32'd1);
            chk("stall_rx_data", 32'(rx_data), 32'hC3);
            chk("stall_tx_ready", 32'(tx_ready), 32'd0);
            chk("stall_shift_en", 32'(shift_en), 32'd0);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        xfer(8'h55, 1'b1, 0); release_rx();

        // Reset on the 4th strobe of 0xA5 aborts the transfer
        tx_data  = 8'hA5;
        tx_dir   = 1'b1;
        tx_valid = 1'b1;
        loop     = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_4th_strobe", 32'(shift_en), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk_reset_values();
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_no_rx_valid", 32'(rx_valid), 32'd0);
        xfer(8'h3C, 1'b0, 0); release_rx();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
